// File: rtl/imem_loader_responder.sv
// Instruction memory with zero-latency fetch read and a byte-serial program loader.
// Loader accepts one byte per cycle in LOAD; core is held until a one-cycle FLUSH pulses core_reset.
module imem_loader_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] FILL_WORD   = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] memory_inst_address,
    output logic [31:0] memory_inst_data,
    output logic        inst_misaligned,
    input  logic        load_start,
    input  logic        load_done,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        core_en,
    output logic        core_reset,
    output logic [15:0] load_words,
    output logic        load_overflow
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] PTR_FULL   = (AW + 1)'(DEPTH_WORDS);
    localparam logic [15:0] WORDS_MAX  = (DEPTH_WORDS > 65535) ? 16'hFFFF : 16'(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [31:0]  r_mem [DEPTH_WORDS];
    logic [AW:0]  r_wr_ptr;
    logic [1:0]   r_byte_idx;
    logic [23:0]  r_asm;
    logic [15:0]  r_load_words;
    logic         r_load_overflow;

    logic         w_rd_active;
    logic         w_aligned;
    logic         w_in_range;
    logic [AW-1:0] w_rd_idx;
    logic         w_byte_acc;
    logic         w_word_done;
    logic         w_flush_wr;
    logic         w_wr_req;
    logic         w_has_room;
    logic         w_wr_en;
    logic [31:0]  w_wr_dat;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control outputs take their RUN values while reset is held, whatever the state register says.
    always_comb begin
        w_state_nxt = r_state;
        core_en     = 1'b1;
        load_ready  = 1'b0;
        core_reset  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_en    = 1'b0;
                load_ready = 1'b1;
                if (load_done) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                core_en     = 1'b0;
                core_reset  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (reset) begin
            core_en    = 1'b1;
            load_ready = 1'b0;
            core_reset = 1'b0;
        end
    end

    assign w_byte_acc  = load_valid & load_ready;
    assign w_word_done = w_byte_acc && (r_byte_idx == 2'd3);
    assign w_flush_wr  = (r_state == ST_FLUSH) && (r_byte_idx != 2'd0) && !reset;
    assign w_wr_req    = w_word_done | w_flush_wr;
    assign w_has_room  = (r_wr_ptr < PTR_FULL);
    assign w_wr_en     = w_wr_req & w_has_room;
    // Unfilled lanes of r_asm are always zero, so a partial word needs no extra masking.
    assign w_wr_dat    = w_word_done ? {load_byte, r_asm} : {8'h00, r_asm};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_byte_idx      <= 2'd0;
            r_asm           <= 24'h0;
            r_load_words    <= 16'h0;
            r_load_overflow <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && load_start) begin
                r_wr_ptr        <= '0;
                r_byte_idx      <= 2'd0;
                r_asm           <= 24'h0;
                r_load_words    <= 16'h0;
                r_load_overflow <= 1'b0;
            end
            if (w_byte_acc) begin
                if (r_byte_idx == 2'd3) begin
                    r_byte_idx <= 2'd0;
                    r_asm      <= 24'h0;
                end else begin
                    r_asm[{r_byte_idx, 3'b000} +: 8] <= load_byte;
                    r_byte_idx                       <= r_byte_idx + 2'd1;
                end
            end
            if (r_state == ST_FLUSH) begin
                r_byte_idx <= 2'd0;
                r_asm      <= 24'h0;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_load_words != WORDS_MAX) begin
                    r_load_words <= r_load_words + 16'd1;
                end
            end
            if (w_wr_req && !w_has_room) begin
                r_load_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_dat;
        end
    end

    assign w_rd_active = (r_state == ST_RUN) | reset;
    assign w_aligned   = (memory_inst_address[1:0] == 2'b00);
    assign w_in_range  = ({1'b0, memory_inst_address} < ADDR_LIMIT);
    assign w_rd_idx    = memory_inst_address[2 +: AW];

    assign memory_inst_data = (w_rd_active && w_aligned && w_in_range) ? r_mem[w_rd_idx] : FILL_WORD;
    assign inst_misaligned  = w_rd_active & (|memory_inst_address[1:0]);
    assign load_words       = reset ? 16'h0 : r_load_words;
    assign load_overflow    = reset ? 1'b0 : r_load_overflow;

endmodule

// File: tb/tb_imem_loader_responder.sv
// Directed bench for imem_loader_responder with a 4-word memory.
module tb_imem_loader_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] memory_inst_address;
    logic [31:0] memory_inst_data;
    logic        inst_misaligned;
    logic        load_start;
    logic        load_done;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        core_en;
    logic        core_reset;
    logic [15:0] load_words;
    logic        load_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    imem_loader_responder #(
        .DEPTH_WORDS(4),
        .FILL_WORD  (32'h0000_0013)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .memory_inst_address(memory_inst_address),
        .memory_inst_data   (memory_inst_data),
        .inst_misaligned    (inst_misaligned),
        .load_start         (load_start),
        .load_done          (load_done),
        .load_valid         (load_valid),
        .load_byte          (load_byte),
        .load_ready         (load_ready),
        .core_en            (core_en),
        .core_reset         (core_reset),
        .load_words         (load_words),
        .load_overflow      (load_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Leaves the bench in the FLUSH cycle.
    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        memory_inst_address = addr;
        #1;
        check_eq(tag, memory_inst_data, exp);
        tick();
    endtask

    initial begin
        logic       hv_valid [7];
        logic [7:0] hv_byte  [7];
        hv_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        hv_byte  = '{8'h11, 8'hFF, 8'hFF, 8'h22, 8'h33, 8'hFF, 8'h44};

        reset               = 1'b1;
        memory_inst_address = 32'h2;
        load_start          = 1'b0;
        load_done           = 1'b0;
        load_valid          = 1'b0;
        load_byte           = 8'h00;
        tick();
        tick();
        check_eq("rst_core_en", 32'(core_en), 32'd1);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("rst_core_reset", 32'(core_reset), 32'd0);
        check_eq("rst_load_words", 32'(load_words), 32'd0);
        check_eq("rst_overflow", 32'(load_overflow), 32'd0);
        check_eq("rst_misaligned", 32'(inst_misaligned), 32'd1);
        reset = 1'b0;
        tick();
        check_eq("post_rst_core_en", 32'(core_en), 32'd1);
        check_eq("post_rst_load_ready", 32'(load_ready), 32'd0);

        // Basic load
        pulse_start();
        check_eq("load_core_en", 32'(core_en), 32'd0);
        check_eq("load_ready", 32'(load_ready), 32'd1);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check_eq("basic_words_1", 32'(load_words), 32'd1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        check_eq("basic_words_2", 32'(load_words), 32'd2);
        check_eq("basic_pre_done_core_reset", 32'(core_reset), 32'd0);
        pulse_done();
        check_eq("flush_core_reset", 32'(core_reset), 32'd1);
        check_eq("flush_core_en", 32'(core_en), 32'd0);
        check_eq("flush_load_ready", 32'(load_ready), 32'd0);
        tick();
        check_eq("run_core_reset", 32'(core_reset), 32'd0);
        check_eq("run_core_en", 32'(core_en), 32'd1);
        check_eq("basic_words_final", 32'(load_words), 32'd2);
        read_chk("basic_mem0", 32'h0, 32'h0000_0013);
        read_chk("basic_mem1", 32'h4, 32'h0010_0093);
        check_eq("basic_misaligned_0", 32'(inst_misaligned), 32'd0);

        // Partial-word flush, last byte accepted on the load_done cycle
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        load_valid = 1'b1;
        load_byte  = 8'hAA;
        load_done  = 1'b1;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        check_eq("partial_flush_core_reset", 32'(core_reset), 32'd1);
        tick();
        check_eq("partial_words", 32'(load_words), 32'd2);
        read_chk("partial_mem0", 32'h0, 32'h0403_0201);
        read_chk("partial_mem1", 32'h4, 32'h0000_00AA);

        // Handshake gaps with stray load_start pulses inside LOAD
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            load_valid = hv_valid[i];
            load_byte  = hv_byte[i];
            load_start = !hv_valid[i];
            tick();
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        check_eq("gap_words", 32'(load_words), 32'd1);
        check_eq("gap_still_loading", 32'(load_ready), 32'd1);
        pulse_done();
        tick();
        read_chk("gap_mem0", 32'h0, 32'h4433_2211);
        read_chk("gap_mem1_kept", 32'h4, 32'h0000_00AA);

        // Overflow: 20 bytes into a 4-word memory
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h10 + i));
        end
        check_eq("ovf_words_full", 32'(load_words), 32'd4);
        check_eq("ovf_flag_before", 32'(load_overflow), 32'd0);
        for (int i = 16; i < 20; i++) begin
            send_byte(8'(8'h10 + i));
        end
        check_eq("ovf_words_sat", 32'(load_words), 32'd4);
        check_eq("ovf_flag_set", 32'(load_overflow), 32'd1);
        pulse_done();
        tick();
        check_eq("ovf_flag_sticky", 32'(load_overflow), 32'd1);
        read_chk("ovf_mem0", 32'h0, 32'h1312_1110);
        read_chk("ovf_mem2", 32'h8, 32'h1B1A_1918);
        read_chk("ovf_mem3", 32'hC, 32'h1F1E_1D1C);

        // Invalid reads in RUN
        read_chk("oob_0x10", 32'h10, 32'h0000_0013);
        memory_inst_address = 32'h10;
        #1;
        check_eq("oob_misaligned", 32'(inst_misaligned), 32'd0);
        read_chk("oob_high", 32'hFFFF_FFFC, 32'h0000_0013);
        read_chk("misal_0x2", 32'h2, 32'h0000_0013);
        memory_inst_address = 32'h2;
        #1;
        check_eq("misal_flag", 32'(inst_misaligned), 32'd1);

        // New session clears the overflow flag; reads return fill during LOAD
        pulse_start();
        check_eq("ovf_cleared", 32'(load_overflow), 32'd0);
        check_eq("words_cleared", 32'(load_words), 32'd0);
        check_eq("load_misaligned", 32'(inst_misaligned), 32'd0);
        read_chk("load_read_fill", 32'h0, 32'h0000_0013);

        // Reset mid-load keeps committed words
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        pulse_done();
        tick();
        read_chk("dead_mem0", 32'h0, 32'hDEAD_BEEF);
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        #1;
        check_eq("midrst_core_en", 32'(core_en), 32'd1);
        check_eq("midrst_load_ready", 32'(load_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("after_rst_core_en", 32'(core_en), 32'd1);
        check_eq("after_rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("after_rst_words", 32'(load_words), 32'd0);
        read_chk("after_rst_mem0", 32'h0, 32'hDEAD_BEEF);

        // Fresh session after reset starts at word 0, lane 0
        pulse_start();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        pulse_done();
        tick();
        check_eq("fresh_words", 32'(load_words), 32'd1);
        read_chk("fresh_mem0", 32'h0, 32'hD4C3_B2A1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader_responder.md
# imem_loader_responder

Instruction-memory responder for the fetch stage. It answers each fetch address with the addressed 32-bit instruction word on the same cycle. It also contains a byte-serial program loader that fills the memory while the core is held. At the end of a load it restarts the core through a one-cycle reset pulse. It sits between the fetch stage's instruction port and the external boot/debug byte stream.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words; a power of two, at least 4.
- FILL_WORD, 32'h0000_0013: word returned for invalid reads (this value is a NOP).
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- memory_inst_address  in  32  byte address from the fetch stage.
- memory_inst_data  out  32  instruction word for that address, combinational.
- inst_misaligned  out  1  high when memory_inst_address[1:0] != 0 in RUN.
- load_start  in  1  pulse that opens a load session.
- load_done  in  1  pulse that closes a load session.
- load_valid  in  1  load_byte holds a valid byte.
- load_byte  in  8  program byte, little-endian order within each word.
- load_ready  out  1  block accepts a byte; a byte transfers when load_valid & load_ready.
- core_en  out  1  fetch/pipeline enable; low while loading.
- core_reset  out  1  one-cycle restart pulse to the core.
- load_words  out  16  number of words written in the current or last session.
- load_overflow  out  1  sticky flag: bytes were dropped because the memory was full.

## Operation
- State machine with three states: RUN, LOAD, FLUSH. Reset state is RUN.
- RUN:
  - core_en=1, load_ready=0, core_reset=0.
  - Word index is memory_inst_address[2 +: log2(DEPTH_WORDS)].
  - memory_inst_data = mem[index] if the address is aligned and memory_inst_address < 4*DEPTH_WORDS; otherwise FILL_WORD.
  - inst_misaligned = |memory_inst_address[1:0].
  - load_start moves the state to LOAD and clears wr_ptr, byte_idx, load_words and load_overflow.
  - load_done is ignored in RUN.
  - If load_start and load_done are high together in RUN, the start is taken.
- LOAD:
  - core_en=0, load_ready=1, memory_inst_data=FILL_WORD, inst_misaligned=0.
  - Each accepted byte goes into assembly lane byte_idx. Lane 0 is bits [7:0].
  - On the 4th byte (byte_idx==3):
    - If wr_ptr < DEPTH_WORDS: write the assembled word to mem[wr_ptr], increment wr_ptr and load_words.
    - Otherwise: discard the word and set load_overflow.
    - byte_idx wraps to 0.
  - load_start is ignored in LOAD.
  - load_done moves the state to FLUSH. If a byte is accepted on the same cycle, that byte is taken first.
- FLUSH (exactly one cycle):
  - core_en=0, load_ready=0, core_reset=1.
  - If byte_idx != 0, write the partial word with unfilled upper lanes set to zero, and increment load_words. The overflow rule above applies to this write.
  - byte_idx is cleared. Next state is RUN.
- Memory array is not reset. Contents are undefined until loaded and are preserved across reset.
- Reset in any state, including mid-load:
  - State returns to RUN; wr_ptr, byte_idx, load_words and load_overflow are cleared.
  - A partially assembled word is discarded.
  - Words already written stay written.
- Writes occur only in LOAD and FLUSH, so there is no read/write collision in RUN.

## Timing
- Output values while reset is asserted and on the first cycle after it:
  - core_en=1, load_ready=0, core_reset=0, load_words=0, load_overflow=0, inst_misaligned per address.
- Read latency is zero: memory_inst_data is combinational from memory_inst_address, so the fetch stage registers it on the same rising edge.
- load_start sampled at edge N: LOAD is active from cycle N+1, with core_en=0 and load_ready=1.
- Byte write: the 4th byte accepted at edge M updates mem and load_words at edge M.
- load_done sampled at edge D: cycle D+1 is FLUSH with core_reset=1; cycle D+2 is RUN with core_en=1.
- load_words saturates at DEPTH_WORDS. load_overflow stays set until the next load_start or reset.

## Test plan
- Basic load:
  - Stimulus: reset; load_start; bytes 13 00 00 00 93 00 10 00; load_done.
  - Response: mem[0]=0x00000013, mem[1]=0x00100093, load_words=2; core_reset high exactly one cycle and core_en=1 the cycle after; address 0x4 then reads 0x00100093 combinationally.
- Partial-word flush:
  - Stimulus: bytes 01 02 03 04 AA, then load_done on the same cycle as the AA byte.
  - Response: mem[0]=0x04030201, mem[1]=0x000000AA, load_words=2.
- Handshake gaps:
  - Stimulus: load_valid toggled 1,0,0,1,1,0,1 carrying 11 22 33 44.
  - Response: only the valid cycles count; mem[0]=0x44332211; load_start pulses during LOAD are ignored.
- Overflow (DEPTH_WORDS=4):
  - Stimulus: 20 bytes.
  - Response: words 0..3 written, the 5th word dropped, load_overflow=1, load_words=4; the flag clears on the next load_start.
- Invalid reads (DEPTH_WORDS=4, RUN):
  - Address 0x10 -> 0x00000013, inst_misaligned=0.
  - Address 0x2 -> 0x00000013, inst_misaligned=1.
  - During LOAD, any address -> 0x00000013.
- Reset mid-load:
  - Stimulus: word 0 loaded as 0xDEADBEEF; new session; 2 bytes; reset.
  - Response: RUN with core_en=1, load_ready=0, load_words=0; mem[0] still 0xDEADBEEF.
